ram_dp_sr_sw_be: RTL and testbench

Simple dual-port RAM with one write port and one read port. The write port has byte enables. Reads are synchronous, with an optional output register stage. A built-in clear sequencer zeroes the whole array after reset, or on request, and reports busy status. It is the next-generation storage primitive after the single-port asynchronous-read RAM, for FIFOs, packet buffers and register files that need concurrent read and write.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_clear_seq.sv | 53 +++++
 rtl/ram_dp_sr_sw_be.sv | 144 ++++++++++++++
 tb/tb_ram_dp_sr_sw_be.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, sequencer states and helpers for the dual-port RAM
package ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } seq_state_t;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - clear sweep sequencer that zeroes every RAM word in turn
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    seq_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            r_count <= '0;
            r_busy  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // busy drops on the same edge that writes the final word
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign clr_we    = (r_state == ST_CLEAR);
    assign clr_addr  = r_count;
    assign init_busy = r_busy;

endmodule

// File: rtl/ram_dp_sr_sw_be.sv
// rtl/ram_dp_sr_sw_be.sv - simple dual-port RAM, byte-enable write, synchronous read, clear sweep
module ram_dp_sr_sw_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             clear_req,
    output logic                             init_busy
);

    localparam int                  NUM_LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("RAM_DEPTH exceeds the address space");
        end
        if (RDW_MODE > RDW_NEW) begin : g_bad_rdw
            $error("RDW_MODE must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    ram_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .RAM_DEPTH     (RAM_DEPTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_req(clear_req),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .init_busy(w_busy)
    );

    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign w_wr_acc      = wr_en & ~w_busy & w_wr_in_range;
    assign w_rd_acc      = rd_en & ~w_busy;

    // Byte-lane merge is done as a read-modify-write of the whole word
    always_comb begin
        w_merged = w_wr_in_range ? r_mem[wr_addr] : '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_be[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if (RDW_MODE == RDW_NEW && w_wr_acc && wr_addr == rd_addr) begin
                w_rd_word = w_merged;
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end
    end

    // Sweep writes only happen while busy, when user writes are blocked
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[wr_addr] <= w_merged;
        end
    end

    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_s2_data;
            logic                  r_s2_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign rd_data  = r_s2_data;
            assign rd_valid = r_s2_valid;
        end else begin : g_no_out_reg
            assign rd_data  = r_s1_data;
            assign rd_valid = r_s1_valid;
        end
    endgenerate

    assign init_busy = w_busy;

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// tb/tb_ram_dp_sr_sw_be.sv - self-checking bench for ram_dp_sr_sw_be against a behavioural model
module tb_ram_dp_sr_sw_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        clear_req = 1'b0;

    logic [31:0] rd_data_o [2];
    logic        rd_valid_o [2];
    logic        busy_o [2];

    always #5 clk = ~clk;

    // instance 0: old-data RDW, single register, 256 words
    ram_dp_sr_sw_be #(
        .RDW_MODE(0), .OUT_REG(0), .RAM_DEPTH(256)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
        .rd_valid(rd_valid_o[0]), .clear_req(clear_req), .init_busy(busy_o[0])
    );

    // instance 1: new-data RDW, extra output register, 200 words
    ram_dp_sr_sw_be #(
        .RDW_MODE(1), .OUT_REG(1), .RAM_DEPTH(200)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
        .rd_valid(rd_valid_o[1]), .clear_req(clear_req), .init_busy(busy_o[1])
    );

    typedef struct {
        int          k;
        int          due;
        logic [31:0] d;
    } rd_t;

    int          depth [2] = '{256, 200};
    int          lat [2]   = '{1, 2};
    int          rdw [2]   = '{0, 1};
    logic [31:0] mm [2][256];
    int          clr_left [2];
    logic [31:0] exp_d [2];
    rd_t         q [$];
    int          cyc = 0;
    int          ncomp = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        ncomp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s[%0d] cyc %0d: observed %h expected %h", tag, k, cyc, got, exp);
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        rd_en = 0; rd_addr = 0; clear_req = 0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic ev;
            ev = 1'b0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].k == k && q[i].due == cyc) begin
                    ev = 1'b1;
                    exp_d[k] = q[i].d;
                    q.delete(i);
                    break;
                end
            end
            chk("rd_valid", k, 32'(rd_valid_o[k]), 32'(ev));
            chk("rd_data", k, rd_data_o[k], exp_d[k]);
            chk("init_busy", k, 32'(busy_o[k]), 32'(clr_left[k] > 0));
        end
    endtask

    // Apply one clock edge to the model using the current inputs, then compare
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            logic        racc, wacc;
            logic [31:0] rw;
            racc = rd_en && clr_left[k] == 0;
            wacc = wr_en && clr_left[k] == 0 && int'(wr_addr) < depth[k];
            rw = (int'(rd_addr) < depth[k]) ? mm[k][rd_addr] : 32'h0;
            if (wacc) begin
                for (int i = 0; i < 4; i++)
                    if (wr_be[i]) mm[k][wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
            end
            if (racc && rdw[k] == 1 && wacc && rd_addr == wr_addr) rw = mm[k][rd_addr];
            if (racc) q.push_back('{k, cyc + lat[k], rw});
            if (clr_left[k] > 0) begin
                mm[k][depth[k] - clr_left[k]] = 32'h0;
                clr_left[k]--;
            end else if (clear_req) begin
                clr_left[k] = depth[k];
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        q.delete();
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = depth[k];
            exp_d[k] = 32'h0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 32'(rd_valid_o[k]), 32'h0);
            chk("rst_data", k, rd_data_o[k], 32'h0);
            chk("rst_busy", k, 32'(busy_o[k]), 32'h1);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Count busy cycles after reset release; a write attempt lands mid-sweep
    task automatic sweep_and_measure();
        int n0, n1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 300; i++) begin
            idle();
            if (i == 10) begin
                wr_en = 1; wr_addr = 8'd3; wr_data = 32'h12345678; wr_be = 4'hf;
            end
            if (busy_o[0]) n0++;
            if (busy_o[1]) n1++;
            step();
        end
        chk("sweep_len", 0, 32'(n0), 32'd256);
        chk("sweep_len", 1, 32'(n1), 32'd200);
    endtask

    task automatic read_all();
        for (int a = 0; a < 256; a++) begin
            idle(); rd_en = 1; rd_addr = 8'(a);
            step();
        end
        idle();
        repeat (3) step();
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        idle(); wr_en = 1; wr_addr = 8'(a); wr_data = d; wr_be = be;
        step();
    endtask

    task automatic rd(input int a);
        idle(); rd_en = 1; rd_addr = 8'(a);
        step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) mm[k][a] = 32'h0;

        do_reset();
        sweep_and_measure();
        read_all();

        // byte-enable merge
        wr(5, 32'hDEADBEEF, 4'b1111);
        wr(5, 32'h11223344, 4'b0101);
        rd(5);
        idle(); repeat (3) step();
        chk("be_merge", 0, rd_data_o[0], 32'hDE22BE44);
        chk("be_merge", 1, rd_data_o[1], 32'hDE22BE44);

        // back-to-back reads show latency and no gaps
        for (int a = 0; a < 4; a++) wr(a, 32'hA0 + 32'(a), 4'hf);
        for (int a = 0; a < 4; a++) rd(a);
        idle(); repeat (3) step();

        // read-during-write, same address
        wr(9, 32'hAA, 4'hf);
        idle(); wr_en = 1; wr_addr = 8'd9; wr_data = 32'h55; wr_be = 4'hf;
        rd_en = 1; rd_addr = 8'd9;
        step();
        idle(); repeat (3) step();
        chk("rdw", 0, rd_data_o[0], 32'hAA);
        chk("rdw", 1, rd_data_o[1], 32'h55);

        // out-of-range write and read on the 200-word instance
        wr(199, 32'hCAFEF00D, 4'hf);
        wr(250, 32'h0BADBEEF, 4'hf);
        rd(250);
        idle(); repeat (3) step();
        chk("oor_read", 1, rd_data_o[1], 32'h0);
        rd(199);
        idle(); repeat (3) step();
        chk("addr199", 1, rd_data_o[1], 32'hCAFEF00D);

        // randomized traffic with occasional clear requests
        for (int i = 0; i < 600; i++) begin
            idle();
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 8'($urandom_range(0, 255));
            wr_data = $urandom;
            wr_be = 4'($urandom_range(0, 15));
            rd_en = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 8'($urandom_range(0, 255));
            clear_req = ($urandom_range(0, 199) == 0);
            step();
        end
        idle();
        repeat (300) step();

        // reset in the middle of a requested sweep restarts it
        idle(); clear_req = 1;
        step();
        idle();
        repeat (100) step();
        do_reset();
        sweep_and_measure();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
